// File: rtl/window_det_pkg.sv
// Shared types and helpers for the sliding-window k-of-N detector.
package window_det_pkg;

    // Largest window the ones counter is sized for.
    localparam int MAX_WIN_LEN = 64;

    // FILLING while fewer than WIN_LEN bits have been accepted; STEADY once the window is full.
    typedef enum logic {
        FILLING = 1'b0,
        STEADY  = 1'b1
    } phase_t;

    // Returns value+1, or value unchanged once it has reached max_value.
    // Callers zero-extend their operands and cast the result back to their own width.
    function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                            input logic [63:0] max_value);
        return (value >= max_value) ? value : value + 64'd1;
    endfunction

endpackage

// File: rtl/window_ones_counter.sv
// Sliding window over the last WIN_LEN accepted bits, with a warm-up fill counter
// and a running count of ones that is updated incrementally.
module window_ones_counter
    import window_det_pkg::*;
#(
    parameter  int WIN_LEN = 3,
    localparam int CNT_W   = $clog2(WIN_LEN + 1)
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             enable,
    input  logic             serial_in,
    output logic [CNT_W-1:0] ones_next,
    output logic             full_next,
    output logic [CNT_W-1:0] ones_count,
    output logic             window_full
);

    logic [WIN_LEN-1:0] window_q;
    logic [WIN_LEN-1:0] window_d;
    logic [CNT_W-1:0]   fill_q;
    logic [CNT_W-1:0]   fill_d;
    phase_t             phase_q;
    phase_t             phase_d;
    logic               oldest;

    // Newest bit enters at index 0; the bit about to leave sits at the top.
    assign oldest      = window_q[WIN_LEN-1];
    assign window_full = (phase_q == STEADY);

    // Next window, fill level, phase and ones count; enable=0 flushes everything to zero.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        window_d  = '0;
        fill_d    = '0;
        ones_next = '0;
        full_next = 1'b0;
        phase_d   = FILLING;
        if (enable) begin
            window_d  = {window_q[WIN_LEN-2:0], serial_in};
            fill_d    = (phase_q == STEADY) ? fill_q : fill_q + CNT_W'(1);
            full_next = (fill_d == CNT_W'(WIN_LEN));
            // Modular CNT_W arithmetic: intermediate wrap cancels, the result is always 0..WIN_LEN.
            ones_next = ones_count + CNT_W'(serial_in)
                      - ((phase_q == STEADY) ? CNT_W'(oldest) : CNT_W'(0));
            phase_d   = full_next ? STEADY : FILLING;
        end
    end

    // Window state registers.
    always_ff @(posedge clk or negedge rstb) begin
        // NOTE: the window is a flop vector rather than a RAM, so it takes the async reset like every other register here.
        if (!rstb) begin
            window_q   <= '0;
            fill_q     <= '0;
            ones_count <= '0;
            phase_q    <= FILLING;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
            window_q   <= window_d;
            fill_q     <= fill_d;
            ones_count <= ones_next;
            phase_q    <= phase_d;
        end
    end

endmodule

// File: rtl/window_kofn_detector.sv
// k-of-N detector: flags when the ones count of the last WIN_LEN accepted bits
// lies in [thr_lo, thr_hi], with level/edge reporting and saturating hit statistics.
module window_kofn_detector
    import window_det_pkg::*;
#(
    parameter  int WIN_LEN = 3,
    localparam int CNT_W   = $clog2(WIN_LEN + 1),
    parameter  int HIT_W   = 16
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             enable,
    input  logic             serial_in,
    input  logic [CNT_W-1:0] thr_lo,
    input  logic [CNT_W-1:0] thr_hi,
    input  logic             edge_mode,
    input  logic             clr_stats,
    output logic             detected,
    output logic [CNT_W-1:0] ones_count,
    output logic             window_full,
    output logic [HIT_W-1:0] hit_cnt,
    output logic             sticky
);

    localparam logic [HIT_W-1:0] HIT_MAX = '1;

    logic [CNT_W-1:0] ones_next;
    logic             full_next;
    logic             match_i;
    logic             match_prev;
    logic             det_next;
    logic [HIT_W-1:0] hit_next;
    logic             sticky_next;

    window_ones_counter #(
        .WIN_LEN (WIN_LEN)
    ) u_counter (
        .clk         (clk),
        .rstb        (rstb),
        .enable      (enable),
        .serial_in   (serial_in),
        .ones_next   (ones_next),
        .full_next   (full_next),
        .ones_count  (ones_count),
        .window_full (window_full)
    );

    // Range match on the post-update count; full_next is 0 while filling or flushing.
    // thr_lo > thr_hi, or bounds beyond WIN_LEN, fall out of the compare naturally.
    always_comb begin
        match_i  = full_next && (thr_lo <= ones_next) && (ones_next <= thr_hi);
        det_next = edge_mode ? (match_i && !match_prev) : match_i;
    end

    // Hit statistics: only enabled edges update them, and clear beats a simultaneous hit.
    always_comb begin
        hit_next    = hit_cnt;
        sticky_next = sticky;
        if (enable) begin
            if (clr_stats) begin
                hit_next    = '0;
                sticky_next = 1'b0;
            end else if (det_next) begin
                hit_next    = HIT_W'(sat_inc(64'(hit_cnt), 64'(HIT_MAX)));
                sticky_next = 1'b1;
            end
        end
    end

    // Output and history registers; match_i is already 0 on flush cycles.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            detected   <= 1'b0;
            match_prev <= 1'b0;
            hit_cnt    <= '0;
            sticky     <= 1'b0;
        end else begin
            detected   <= det_next;
            match_prev <= match_i;
            hit_cnt    <= hit_next;
            sticky     <= sticky_next;
        end
    end

endmodule

// File: tb/tb_window_kofn_detector.sv
// Self-checking bench: vector table on a WIN_LEN=3 instance, hand sequences for
// WIN_LEN=8 and HIT_W=2 corners, and a randomized run against a queue-based model.
module tb_window_kofn_detector;

    logic       clk = 1'b0;
    logic       rstb;
    logic       enable;
    logic       serial_in;
    logic       edge_mode;
    logic       clr_stats;
    logic [1:0] thr_lo3, thr_hi3;
    logic [3:0] thr_lo8, thr_hi8;

    logic        det3, full3, stk3;
    logic [1:0]  ones3;
    logic [15:0] hit3;
    logic        det8, full8, stk8;
    logic [3:0]  ones8;
    logic [15:0] hit8;
    logic        deth, fullh, stkh;
    logic [1:0]  onesh;
    logic [1:0]  hith;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    window_kofn_detector #(.WIN_LEN(3), .HIT_W(16)) dut3 (
        .clk(clk), .rstb(rstb), .enable(enable), .serial_in(serial_in),
        .thr_lo(thr_lo3), .thr_hi(thr_hi3), .edge_mode(edge_mode), .clr_stats(clr_stats),
        .detected(det3), .ones_count(ones3), .window_full(full3), .hit_cnt(hit3), .sticky(stk3)
    );

    window_kofn_detector #(.WIN_LEN(8), .HIT_W(16)) dut8 (
        .clk(clk), .rstb(rstb), .enable(enable), .serial_in(serial_in),
        .thr_lo(thr_lo8), .thr_hi(thr_hi8), .edge_mode(edge_mode), .clr_stats(clr_stats),
        .detected(det8), .ones_count(ones8), .window_full(full8), .hit_cnt(hit8), .sticky(stk8)
    );

    window_kofn_detector #(.WIN_LEN(3), .HIT_W(2)) dut_h2 (
        .clk(clk), .rstb(rstb), .enable(enable), .serial_in(serial_in),
        .thr_lo(thr_lo3), .thr_hi(thr_hi3), .edge_mode(edge_mode), .clr_stats(clr_stats),
        .detected(deth), .ones_count(onesh), .window_full(fullh), .hit_cnt(hith), .sticky(stkh)
    );

    typedef struct {
        logic        en;
        logic        din;
        logic        edm;
        logic        clr;
        logic [1:0]  lo;
        logic [1:0]  hi;
        logic        det;
        logic [1:0]  ones;
        logic        full;
        logic [15:0] hit;
        logic        stk;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, take the edge, then settle just after it.
    task automatic step(input logic en, input logic din, input logic edm, input logic clr);
        enable    = en;
        serial_in = din;
        edge_mode = edm;
        clr_stats = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rstb = 1'b0;
        #2;
        rstb = 1'b1;
    endtask

    function automatic void add(input logic en, input logic din, input logic edm, input logic clr,
                                input logic [1:0] lo, input logic [1:0] hi,
                                input logic det, input logic [1:0] ones, input logic full,
                                input logic [15:0] hit, input logic stk);
        vec_t v;
        v.en = en; v.din = din; v.edm = edm; v.clr = clr; v.lo = lo; v.hi = hi;
        v.det = det; v.ones = ones; v.full = full; v.hit = hit; v.stk = stk;
        tbl.push_back(v);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got time limit, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   q[$];
        logic mp, stk, edm, m, edet;
        int   hit, ones;
        logic en, b, clr;
        logic [3:0] lo, hi;

        rstb = 1'b0; enable = 1'b0; serial_in = 1'b0; edge_mode = 1'b0; clr_stats = 1'b0;
        thr_lo3 = 2'd2; thr_hi3 = 2'd2; thr_lo8 = 4'd6; thr_hi8 = 4'd8;
        #1;
        check("reset det", det3, 0);
        check("reset ones", ones3, 0);
        check("reset full", full3, 0);
        check("reset hit", hit3, 0);
        check("reset sticky", stk3, 0);
        #5;
        rstb = 1'b1;
        @(posedge clk);
        #1;

        // en din edm clr lo hi | det ones full hit sticky
        // Level mode, window 3, count exactly 2: bits 0,1,1,0,1,1,1
        add(1,0,0,0,2,2, 0,0,0,0,0);
        add(1,1,0,0,2,2, 0,1,0,0,0);
        add(1,1,0,0,2,2, 1,2,1,1,1);
        add(1,0,0,0,2,2, 1,2,1,2,1);
        add(1,1,0,0,2,2, 1,2,1,3,1);
        add(1,1,0,0,2,2, 1,2,1,4,1);
        add(1,1,0,0,2,2, 0,3,1,4,1);
        // Flush, then the same stream in edge mode
        add(0,0,0,0,2,2, 0,0,0,4,1);
        add(1,0,1,0,2,2, 0,0,0,4,1);
        add(1,1,1,0,2,2, 0,1,0,4,1);
        add(1,1,1,0,2,2, 1,2,1,5,1);
        add(1,0,1,0,2,2, 0,2,1,5,1);
        add(1,1,1,0,2,2, 0,2,1,5,1);
        add(1,1,1,0,2,2, 0,2,1,5,1);
        add(1,1,1,0,2,2, 0,3,1,5,1);
        // Warm-up restarts on flush: 1,1, flush, 1,1,1
        add(0,0,0,0,2,2, 0,0,0,5,1);
        add(1,1,0,0,2,2, 0,1,0,5,1);
        add(1,1,0,0,2,2, 0,2,0,5,1);
        add(0,0,0,0,2,2, 0,0,0,5,1);
        add(1,1,0,0,2,2, 0,1,0,5,1);
        add(1,1,0,0,2,2, 0,2,0,5,1);
        add(1,1,0,0,2,2, 0,3,1,5,1);
        // Inverted range never matches
        add(1,0,0,0,3,1, 0,2,1,5,1);
        add(1,1,0,0,3,1, 0,2,1,5,1);
        add(1,1,0,0,3,1, 0,2,1,5,1);
        // Full range matches every full cycle
        add(1,0,0,0,0,3, 1,2,1,6,1);
        add(1,0,0,0,0,3, 1,1,1,7,1);
        add(1,0,0,0,0,3, 1,0,1,8,1);
        add(1,1,0,0,0,3, 1,1,1,9,1);
        // Clear wins over a simultaneous detect
        add(1,1,0,1,0,3, 1,2,1,0,0);
        add(1,1,0,0,0,3, 1,3,1,1,1);

        foreach (tbl[i]) begin
            thr_lo3 = tbl[i].lo;
            thr_hi3 = tbl[i].hi;
            step(tbl[i].en, tbl[i].din, tbl[i].edm, tbl[i].clr);
            check($sformatf("vec%0d det", i),    det3,  tbl[i].det);
            check($sformatf("vec%0d ones", i),   ones3, tbl[i].ones);
            check($sformatf("vec%0d full", i),   full3, tbl[i].full);
            check($sformatf("vec%0d hit", i),    hit3,  tbl[i].hit);
            check($sformatf("vec%0d sticky", i), stk3,  tbl[i].stk);
        end

        // Window 8, range 6..8: eight 1s then eight 0s
        pulse_reset();
        thr_lo8 = 4'd6; thr_hi8 = 4'd8;
        for (int k = 1; k <= 16; k++) begin
            int exp_ones;
            exp_ones = (k <= 8) ? k : 16 - k;
            step(1'b1, (k <= 8), 1'b0, 1'b0);
            check($sformatf("w8 bit%0d ones", k), ones8, exp_ones);
            check($sformatf("w8 bit%0d full", k), full8, (k >= 8));
            check($sformatf("w8 bit%0d det", k),  det8,  (k >= 8) && (exp_ones >= 6));
        end
        check("w8 hit", hit8, 3);

        // Async reset mid-stream clears outputs without a clock edge
        step(1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        rstb = 1'b0;
        #1;
        check("async det", det8, 0);
        check("async ones", ones8, 0);
        check("async full", full8, 0);
        check("async hit", hit8, 0);
        check("async sticky", stk8, 0);
        check("async w3 ones", ones3, 0);
        #1;
        rstb = 1'b1;

        // HIT_W=2 saturation, then clear together with a detect
        thr_lo3 = 2'd0; thr_hi3 = 2'd3;
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            check($sformatf("h2 bit%0d hit", k), hith, (k < 3) ? 0 : ((k - 2 > 3) ? 3 : k - 2));
            check($sformatf("h2 bit%0d det", k), deth, (k >= 3));
        end
        check("h2 ones", onesh, 3);
        check("h2 full", fullh, 1);
        check("h2 sticky", stkh, 1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("h2 clr det", deth, 1);
        check("h2 clr hit", hith, 0);
        check("h2 clr sticky", stkh, 0);

        // Randomized run on the window-8 instance against a queue model
        pulse_reset();
        q.delete();
        mp = 0; stk = 0; hit = 0; edm = 0;
        lo = 4'd5; hi = 4'd8;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 19) == 0) begin
                lo = 4'($urandom_range(0, 15));
                hi = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 1) == 1) begin
                    lo = 4'($urandom_range(0, 6));
                    hi = 4'($urandom_range(4, 8));
                end
            end
            if ($urandom_range(0, 31) == 0) edm = ~edm;
            en  = ($urandom_range(0, 9) != 0);
            b   = 1'($urandom_range(0, 1));
            clr = en && ($urandom_range(0, 24) == 0);
            thr_lo8 = lo;
            thr_hi8 = hi;
            step(en, b, edm, clr);

            edet = 0;
            if (!en) begin
                q.delete();
                mp = 0;
            end else begin
                q.push_back(b);
                if (q.size() > 8) void'(q.pop_front());
                ones = 0;
                foreach (q[j]) ones += int'(q[j]);
                m    = (q.size() == 8) && (int'(lo) <= ones) && (ones <= int'(hi));
                edet = edm ? (m && !mp) : m;
                mp   = m;
                if (clr) begin
                    hit = 0;
                    stk = 0;
                end else if (edet) begin
                    if (hit < 65535) hit++;
                    stk = 1;
                end
            end
            ones = 0;
            foreach (q[j]) ones += int'(q[j]);
            check($sformatf("rnd%0d det", c),    det8,  edet);
            check($sformatf("rnd%0d ones", c),   ones8, ones);
            check($sformatf("rnd%0d full", c),   full8, (q.size() == 8));
            check($sformatf("rnd%0d hit", c),    hit8,  hit);
            check($sformatf("rnd%0d sticky", c), stk8,  stk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/window_kofn_detector.md
Name: window_kofn_detector

Overview:
Parametrised sliding-window k-of-N detector for a serial bit stream. It keeps a running count of 1s over the last WIN_LEN accepted bits and flags when that count lies inside a runtime range [thr_lo, thr_hi]. Successor to the fixed "2 of last 3" detector: window length is generic, thresholds are run-time, and it adds level/edge reporting plus hit statistics. It sits on the serial receive path next to the existing pattern logic.

Parameters:
WIN_LEN, 3, window length N in bits; legal range 2..64.
CNT_W, $clog2(WIN_LEN+1), width of ones count and thresholds; derived, never overridden.
HIT_W, 16, width of saturating hit counter.

Ports:
clk  in  1  clock, all logic on rising edge
rstb  in  1  asynchronous, active-low reset
enable  in  1  1 = accept serial_in this cycle; 0 = synchronous flush of window state
serial_in  in  1  input bit, sampled when enable=1
thr_lo  in  CNT_W  lower bound of ones count, inclusive
thr_hi  in  CNT_W  upper bound of ones count, inclusive
edge_mode  in  1  0 = level reporting; 1 = report only the first cycle of each match run
clr_stats  in  1  synchronous clear of hit_cnt and sticky
detected  out  1  registered detection flag
ones_count  out  CNT_W  registered 1s count in current window
window_full  out  1  window holds WIN_LEN valid bits
hit_cnt  out  HIT_W  number of detected pulses; saturates
sticky  out  1  set on any detected=1; held until clr_stats

Behaviour:
- Reset (rstb=0, async): window shift register=0, fill=0, ones_count=0, window_full=0, detected=0, match_prev=0, hit_cnt=0, sticky=0.
- enable=0 on a clock edge: window, fill, ones_count, window_full, detected and match_prev clear to 0. hit_cnt and sticky are retained. Any data mid-window is discarded, so warm-up restarts.
- enable=1 on a clock edge:
  - New bit shifts into the window.
  - When the window is full, the oldest bit shifts out.
  - ones_next = ones_count + serial_in − (window_full ? oldest : 0). Never over/underflows.
  - fill increments, saturating at WIN_LEN. window_full = (fill_next == WIN_LEN).
- Warm-up: match is evaluated only when fill_next == WIN_LEN. The first possible detect is the cycle after the WIN_LEN-th accepted bit.
- match_i = full_next && (thr_lo <= ones_next) && (ones_next <= thr_hi), using current-cycle thresholds.
  - thr_lo > thr_hi never matches.
  - Threshold values above WIN_LEN simply never match.
- Output selection:
  - Level mode: detected <= match_i.
  - Edge mode: detected <= match_i && !match_prev. match_prev <= match_i every enabled cycle.
  - Changing edge_mode takes effect on the next enabled edge. match_prev history is kept.
- Latency: detected, ones_count and window_full reflect the bit sampled on the previous edge (1-cycle registered latency, as before).
- Statistics:
  - On each edge where detected_next=1, hit_cnt increments (saturating at 2^HIT_W−1) and sticky sets.
  - If clr_stats=1 in the same cycle, clear wins: hit_cnt=0, sticky=0.
  - Statistics update only on enabled cycles.
- No FSM states are enumerated. Window contents plus a fill counter replace the one-hot history states. Control is a two-state phase: FILLING (fill<WIN_LEN) then STEADY.

Decomposition:
- Package window_det_pkg:
  - typedef phase_t {FILLING, STEADY}.
  - Function for saturating increment.
  - Constant MAX_WIN_LEN=64.
- Sub-module window_ones_counter (WIN_LEN): holds the shift register, fill and running count; outputs ones_next, full_next and the registered values.
- The top adds threshold compare, edge logic and statistics.

Test Plan:
1. WIN_LEN=3, thr_lo=thr_hi=2, level mode; bits 0,1,1,0,1,1,1 → detected 0,0,1,1,1,1,0 (each one cycle after its bit); ones_count 0,1,2,2,2,2,3; window_full rises after the 3rd bit.
2. Same stream with edge_mode=1 → detected 0,0,1,0,0,0,0; hit_cnt=1, sticky=1.
3. WIN_LEN=8, thr_lo=6, thr_hi=8; eight 1s then eight 0s → detected high after bits 8,9,10; low from bit 11 (ones=5); ones_count falls 8→0 by bit 16.
4. Warm-up and flush: WIN_LEN=3, stream 1,1; drop enable for one cycle; then 1,1 → no detect; ones_count=0 during the flush cycle; window_full=0 until the 3rd post-flush bit.
5. Thresholds: thr_lo=3, thr_hi=1 on any stream → detected stays 0. thr_lo=0, thr_hi=WIN_LEN → detected=1 every cycle once full.
6. Statistics: HIT_W=2, level mode, continuous match → hit_cnt saturates at 3. clr_stats together with a detect → hit_cnt=0, sticky=0 that cycle. Async rstb pulse mid-stream → all outputs 0 immediately.
